// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, one-cycle
// valid / frame_err / overrun strobes feeding the downstream byte FIFO.
module uart_rx #(
  parameter int CLK_FREQ     = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       fifo_full,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MID = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_nxt;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          valid_nxt, frame_err_nxt, overrun_nxt;
  logic          stop_sample;

  // Synchroniser flops reset high so a reset never looks like a start edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default every comb output first; a missing branch would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rx_s) state_nxt = START;
      START: if (cnt == CNT_MID) state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (cnt == CNT_END && bitcnt == 3'd7) state_nxt = STOP;
      STOP:  if (cnt == CNT_END) state_nxt = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // fifo_full only matters on the single stop-bit sample cycle.
  assign stop_sample = (state == STOP) && (cnt == CNT_END);

  always_comb begin
    valid_nxt     = stop_sample &&  rx_s && !fifo_full;
    overrun_nxt   = stop_sample &&  rx_s &&  fifo_full;
    frame_err_nxt = stop_sample && !rx_s;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      bitcnt    <= 3'd0;
      shreg     <= 8'h00;
      data_out  <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // Counter wraps each bit period so DATA can sample consecutive bits.
      if (state_nxt != state || cnt == CNT_END) cnt <= '0;
      else                                      cnt <= cnt + 1'b1;

      if (state != DATA)       bitcnt <= 3'd0;
      else if (cnt == CNT_END) bitcnt <= bitcnt + 3'd1;

      if (state == DATA && cnt == CNT_END) shreg <= {rx_s, shreg[7:1]};

      if (valid_nxt) data_out <= shreg;
      valid     <= valid_nxt;
      frame_err <= frame_err_nxt;
      overrun   <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against a frame-level outcome model.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 104;
  localparam int EXP_LAT = 990;

  logic       clk = 1'b0;
  logic       rst, rx, fifo_full;
  logic [7:0] data_out;
  logic       valid, frame_err, overrun, busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int v_cnt = 0, fe_cnt = 0, ov_cnt = 0, excl_viol = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] vq_data[$];
  int         vq_cyc[$];
  logic [7:0] exp_last;
  int         start_cyc;

  uart_rx #(.CLK_FREQ(12000000), .BAUD(115200)) dut (
    .clk(clk), .rst(rst), .rx(rx), .fifo_full(fifo_full),
    .data_out(data_out), .valid(valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #41.667 clk = ~clk;
  always @(posedge clk) cyc++;

  // Event recorder, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (valid) begin
        v_cnt++;
        vq_data.push_back(data_out);
        vq_cyc.push_back(cyc);
      end
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (int'(valid) + int'(frame_err) + int'(overrun) > 1) excl_viol++;
      if (prev_pulse && (valid || frame_err || overrun)) excl_viol++;
      prev_pulse = valid || frame_err || overrun;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first and the given stop level; rx is left at stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    start_cyc = cyc;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = stop;
    wait_cycles(CPB);
  endtask

  task automatic test_reset;
    total++;
    if ({data_out, valid, frame_err, overrun, busy} !== 12'h000) begin
      bad++;
      $display("FAIL reset_state: got data=%h v=%b fe=%b ov=%b busy=%b expected all zero",
               data_out, valid, frame_err, overrun, busy);
    end
    exp_last = 8'h00;
  endtask

  task automatic test_single;
    int v0, fe0, ov0, lat;
    v0 = v_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    vq_data.delete(); vq_cyc.delete();
    fifo_full = 1'b0;
    send_frame(8'hAA, 1'b1);
    wait_cycles(20);
    total++;
    if (v_cnt - v0 !== 1) begin
      bad++; $display("FAIL single_valid_count: got %0d expected 1", v_cnt - v0);
    end
    total++;
    if (vq_data.size() < 1 || vq_data[0] !== 8'hAA) begin
      bad++; $display("FAIL single_data: got %h expected aa", data_out);
    end
    total++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      bad++; $display("FAIL single_errors: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    lat = (vq_cyc.size() > 0) ? vq_cyc[0] - start_cyc : -1;
    total++;
    if (lat < EXP_LAT - 2 || lat > EXP_LAT + 2) begin
      bad++; $display("FAIL single_latency: got %0d expected %0d +/-2", lat, EXP_LAT);
    end
    exp_last = 8'hAA;
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes[3] = '{8'h55, 8'h00, 8'hFF};
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    vq_data.delete(); vq_cyc.delete();
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1);
    wait_cycles(20);
    total++;
    if (vq_data.size() !== 3) begin
      bad++; $display("FAIL b2b_count: got %0d expected 3", vq_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i >= vq_data.size() || vq_data[i] !== bytes[i]) begin
        bad++;
        $display("FAIL b2b_data%0d: got %h expected %h", i,
                 (i < vq_data.size()) ? vq_data[i] : 8'hxx, bytes[i]);
      end
    end
    total++;
    if (fe_cnt != fe0 || ov_cnt != ov0) begin
      bad++; $display("FAIL b2b_errors: got fe=%0d ov=%0d expected 0 0", fe_cnt - fe0, ov_cnt - ov0);
    end
    exp_last = 8'hFF;
  endtask

  task automatic test_glitch;
    int v0, fe0, ov0;
    v0 = v_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    rx = 1'b0;
    wait_cycles(20);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL glitch_busy_high: got %b expected 1", busy);
    end
    rx = 1'b1;
    wait_cycles(150);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL glitch_busy_low: got %b expected 0", busy);
    end
    total++;
    if (v_cnt != v0 || fe_cnt != fe0 || ov_cnt != ov0) begin
      bad++; $display("FAIL glitch_pulses: got v=%0d fe=%0d ov=%0d expected 0 0 0",
                      v_cnt - v0, fe_cnt - fe0, ov_cnt - ov0);
    end
  endtask

  task automatic test_frame_err;
    int v0, fe0, ov0;
    v0 = v_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0);
    wait_cycles(3000);
    rx = 1'b1;
    wait_cycles(50);
    total++;
    if (fe_cnt - fe0 !== 1) begin
      bad++; $display("FAIL break_frame_err: got %0d expected 1", fe_cnt - fe0);
    end
    total++;
    if (v_cnt != v0 || ov_cnt != ov0) begin
      bad++; $display("FAIL break_no_valid: got v=%0d ov=%0d expected 0 0", v_cnt - v0, ov_cnt - ov0);
    end
    total++;
    if (data_out !== exp_last) begin
      bad++; $display("FAIL break_data_kept: got %h expected %h", data_out, exp_last);
    end
    vq_data.delete();
    send_frame(8'h81, 1'b1);
    wait_cycles(20);
    total++;
    if (vq_data.size() !== 1 || data_out !== 8'h81) begin
      bad++; $display("FAIL break_recover: got n=%0d data=%h expected 1 81", vq_data.size(), data_out);
    end
    exp_last = 8'h81;
  endtask

  task automatic test_overrun;
    int v0, ov0;
    v0 = v_cnt; ov0 = ov_cnt;
    fifo_full = 1'b1;
    send_frame(8'h12, 1'b1);
    fifo_full = 1'b0;
    wait_cycles(20);
    total++;
    if (ov_cnt - ov0 !== 1 || v_cnt != v0) begin
      bad++; $display("FAIL overrun_pulse: got ov=%0d v=%0d expected 1 0", ov_cnt - ov0, v_cnt - v0);
    end
    total++;
    if (data_out !== exp_last) begin
      bad++; $display("FAIL overrun_data_kept: got %h expected %h", data_out, exp_last);
    end
    send_frame(8'h12, 1'b1);
    wait_cycles(20);
    total++;
    if (v_cnt - v0 !== 1 || data_out !== 8'h12) begin
      bad++; $display("FAIL overrun_retry: got v=%0d data=%h expected 1 12", v_cnt - v0, data_out);
    end
    exp_last = 8'h12;
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b = 8'h77;
    int v0, fe0, ov0;
    rx = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_cycles(CPB);
    end
    rx = b[4];
    wait_cycles(CPB / 2);
    rst = 1'b1;
    #1;
    total++;
    if ({data_out, valid, frame_err, overrun, busy} !== 12'h000) begin
      bad++;
      $display("FAIL midreset_clear: got data=%h v=%b fe=%b ov=%b busy=%b expected all zero",
               data_out, valid, frame_err, overrun, busy);
    end
    wait_cycles(5);
    rx = 1'b1;
    rst = 1'b0;
    exp_last = 8'h00;
    wait_cycles(20);
    v0 = v_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    vq_data.delete();
    send_frame(8'h77, 1'b1);
    wait_cycles(20);
    total++;
    if (v_cnt - v0 !== 1 || data_out !== 8'h77 || fe_cnt != fe0 || ov_cnt != ov0) begin
      bad++; $display("FAIL midreset_recover: got v=%0d data=%h expected 1 77", v_cnt - v0, data_out);
    end
    exp_last = 8'h77;
  endtask

  // Frame-level model: bad stop -> frame error; good stop with full FIFO -> overrun; else byte.
  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    logic       stop, full;
    int v0, fe0, ov0, efe, eov;
    v0 = v_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    efe = 0; eov = 0;
    vq_data.delete();
    for (int n = 0; n < 12; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      full = ($urandom_range(0, 3) == 0);
      fifo_full = full;
      send_frame(b, stop);
      fifo_full = 1'b0;
      rx = 1'b1;
      wait_cycles($urandom_range(8, 40));
      if (!stop)     efe++;
      else if (full) eov++;
      else begin
        exp_q.push_back(b);
        exp_last = b;
      end
    end
    total++;
    if (fe_cnt - fe0 != efe || ov_cnt - ov0 != eov || v_cnt - v0 != exp_q.size()) begin
      bad++;
      $display("FAIL random_counts: got v=%0d fe=%0d ov=%0d expected %0d %0d %0d",
               v_cnt - v0, fe_cnt - fe0, ov_cnt - ov0, exp_q.size(), efe, eov);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= vq_data.size() || vq_data[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL random_byte%0d: got %h expected %h", i,
                 (i < vq_data.size()) ? vq_data[i] : 8'hxx, exp_q[i]);
      end
    end
    total++;
    if (data_out !== exp_last) begin
      bad++; $display("FAIL random_last: got %h expected %h", data_out, exp_last);
    end
  endtask

  task automatic test_exclusivity;
    total++;
    if (excl_viol !== 0) begin
      bad++; $display("FAIL pulse_exclusive: got %0d violations expected 0", excl_viol);
    end
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    fifo_full = 1'b0;
    wait_cycles(5);
    rst = 1'b0;
    wait_cycles(10);
    test_reset;
    test_single;
    wait_cycles(10);
    test_back_to_back;
    wait_cycles(10);
    test_glitch;
    test_frame_err;
    wait_cycles(10);
    test_overrun;
    wait_cycles(10);
    test_reset_mid_frame;
    wait_cycles(10);
    test_random;
    test_exclusivity;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
